// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : cache_pkg                                                 |
// | Purpose   : Shared types for the L1 data cache miss sequencer.       |
// |             line_state_t is the per-line coherence state written     |
// |             into the state array; cc_state_t is the sequencer state. |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package cache_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    UPGRADE   = 3'd4,
    ERROR     = 3'd5
  } cc_state_t;

  // States in which an ACE transaction is outstanding and the wait
  // counter is running.
  function automatic logic is_wait_state(input cc_state_t s);
    return (s == WRITEBACK) || (s == ALLOCATE) || (s == UPGRADE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : cc_wait_timer                                            |
// | Purpose   : Counts cycles spent waiting for ace_ready and flags when |
// |             the last permitted cycle has been reached.               |
// | Ports     : clk, rst   clock / synchronous active-high reset         |
// |             clear      restart count at 0 (priority over inc)        |
// |             inc        add one to the count                          |
// |             expired    count == TIMEOUT_CYCLES-1                     |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module cc_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : cache_controller                                         |
// | Purpose   : Per-line-miss sequencer of the L1 data cache. Takes one  |
// |             CPU load/store, runs the tag lookup and then completes   |
// |             it as a hit, a dirty-victim writeback followed by an     |
// |             allocate, an allocate, or a shared-to-unique upgrade.    |
// | Ports     : clk, rst                 clock / sync active-high reset  |
// |             cpu_req_valid/we, cpu_ready   CPU handshake               |
// |             lookup_en, tag_hit, line_valid, line_dirty, line_shared  |
// |                                       tag/state array lookup          |
// |             data_we, refill_we, state_upd, new_state  array writes   |
// |             read_req, write_req, invalid_req, ace_ready, snoop_busy  |
// |                                       ace_controller interface        |
// |             timeout_err              sticky fatal flag                |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module cache_controller
  import cache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req_valid,
  input  logic       cpu_req_we,
  output logic       cpu_ready,
  output logic       lookup_en,
  input  logic       tag_hit,
  input  logic       line_valid,
  input  logic       line_dirty,
  input  logic       line_shared,
  output logic       data_we,
  output logic       refill_we,
  output logic       state_upd,
  output logic [1:0] new_state,
  output logic       read_req,
  output logic       write_req,
  output logic       invalid_req,
  input  logic       ace_ready,
  input  logic       snoop_busy,
  output logic       timeout_err
);

  cc_state_t state;
  cc_state_t state_next;
  logic      is_store;
  logic      timer_clear;
  logic      timer_inc;
  logic      timer_expired;

  cc_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      is_store <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && lookup_en) begin
        is_store <= cpu_req_we;
      end
    end
  end

  always_comb begin
    state_next  = state;
    cpu_ready   = 1'b0;
    lookup_en   = 1'b0;
    data_we     = 1'b0;
    refill_we   = 1'b0;
    state_upd   = 1'b0;
    new_state   = INVALID;
    read_req    = 1'b0;
    write_req   = 1'b0;
    invalid_req = 1'b0;
    timeout_err = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req_valid && !snoop_busy) begin
          lookup_en  = 1'b1;
          state_next = LOOKUP;
        end
      end

      LOOKUP: begin
        if (tag_hit) begin
          if (!is_store) begin
            cpu_ready  = 1'b1;
            state_next = IDLE;
          end else if (!line_shared) begin
            // Store to a line already held unique: write in place.
            data_we    = 1'b1;
            state_upd  = 1'b1;
            new_state  = MODIFIED;
            cpu_ready  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = UPGRADE;
          end
        end else if (line_valid && line_dirty) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end

      WRITEBACK: begin
        write_req = 1'b1;
        if (ace_ready) begin
          state_next = ALLOCATE;
        end else if (timer_expired) begin
          state_next = ERROR;
        end
      end

      ALLOCATE: begin
        read_req = 1'b1;
        if (ace_ready) begin
          // Refill lands as SHARED; re-run the lookup so a store can
          // fall through to the upgrade path.
          refill_we  = 1'b1;
          state_upd  = 1'b1;
          new_state  = SHARED;
          lookup_en  = 1'b1;
          state_next = LOOKUP;
        end else if (timer_expired) begin
          state_next = ERROR;
        end
      end

      UPGRADE: begin
        invalid_req = 1'b1;
        if (ace_ready) begin
          state_upd  = 1'b1;
          new_state  = MODIFIED;
          data_we    = 1'b1;
          cpu_ready  = 1'b1;
          state_next = IDLE;
        end else if (timer_expired) begin
          state_next = ERROR;
        end
      end

      ERROR: begin
        timeout_err = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Any state change restarts the wait count, so each wait state is
    // entered with a fresh budget.
    timer_clear = (state_next != state);
    timer_inc   = is_wait_state(state) && !ace_ready;

    // Hold every output quiet while reset is asserted, even when the
    // state register still reflects an aborted transaction.
    if (rst) begin
      cpu_ready   = 1'b0;
      lookup_en   = 1'b0;
      data_we     = 1'b0;
      refill_we   = 1'b0;
      state_upd   = 1'b0;
      new_state   = INVALID;
      read_req    = 1'b0;
      write_req   = 1'b0;
      invalid_req = 1'b0;
      timeout_err = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_cache_controller                                      |
// | Purpose   : Self-checking bench for cache_controller. Acts as the    |
// |             CPU, the tag/state datapath and the ace_controller, and  |
// |             compares each transaction with a transaction-level       |
// |             expectation (request list, state writes, latency).       |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_cache_controller;

  localparam int TIMEOUT_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req_valid;
  logic       cpu_req_we;
  logic       cpu_ready;
  logic       lookup_en;
  logic       tag_hit;
  logic       line_valid;
  logic       line_dirty;
  logic       line_shared;
  logic       data_we;
  logic       refill_we;
  logic       state_upd;
  logic [1:0] new_state;
  logic       read_req;
  logic       write_req;
  logic       invalid_req;
  logic       ace_ready;
  logic       snoop_busy;
  logic       timeout_err;

  int checks = 0;
  int fails  = 0;

  cache_controller #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_we    (cpu_req_we),
    .cpu_ready     (cpu_ready),
    .lookup_en     (lookup_en),
    .tag_hit       (tag_hit),
    .line_valid    (line_valid),
    .line_dirty    (line_dirty),
    .line_shared   (line_shared),
    .data_we       (data_we),
    .refill_we     (refill_we),
    .state_upd     (state_upd),
    .new_state     (new_state),
    .read_req      (read_req),
    .write_req     (write_req),
    .invalid_req   (invalid_req),
    .ace_ready     (ace_ready),
    .snoop_busy    (snoop_busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {cpu_ready, lookup_en, data_we, refill_we, state_upd, new_state,
            read_req, write_req, invalid_req, timeout_err};
  endfunction

  // One complete CPU transaction. The expectation is built from the
  // cache rules alone: which ACE requests must be issued, which state
  // writes happen, and when cpu_ready must appear. w0..w2 give the cycle
  // (1-based, within each request) on which ace_ready is returned.
  task automatic run_txn(input string name, input bit we, input bit hit,
                         input bit valid, input bit dirty, input bit shared,
                         input int w0, input int w1, input int w2);
    int   waits[3];
    int   exp_req[$];
    int   exp_upd[$];
    int   obs_req[$];
    int   exp_seq, obs_seq, upd_exp_seq, upd_obs_seq;
    int   exp_ready, obs_ready, n_data, n_refill, n_lookup, req_cyc, t;
    int   cur_req, prev_req, idx;
    bit   alloc, pend, refilled, done, ready_data_ok, err_seen;

    waits[0] = w0; waits[1] = w1; waits[2] = w2;

    // Expected behaviour (codes: 1 = WriteClean, 2 = ReadShared, 3 = MakeUnique)
    alloc = !hit;
    if (hit) begin
      if (we && shared) exp_req.push_back(3);
    end else begin
      if (valid && dirty) exp_req.push_back(1);
      exp_req.push_back(2);
      if (we) exp_req.push_back(3);   // refilled line is SHARED
    end
    if (alloc) exp_upd.push_back(1);  // SHARED after refill
    if (we)    exp_upd.push_back(2);  // MODIFIED after store
    exp_ready = 1 + (alloc ? 1 : 0);
    foreach (exp_req[i]) exp_ready += waits[i];
    exp_seq = 0;
    foreach (exp_req[i]) exp_seq = exp_seq * 4 + exp_req[i];
    upd_exp_seq = 0;
    foreach (exp_upd[i]) upd_exp_seq = upd_exp_seq * 4 + exp_upd[i] + 1;

    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    snoop_busy    = 1'b0;
    obs_ready = -1; pend = 0; refilled = 0; prev_req = 0; req_cyc = 0;
    n_data = 0; n_refill = 0; n_lookup = 0; upd_obs_seq = 0;
    ready_data_ok = 0; err_seen = 0; done = 0; t = 0;

    while (!done && t < 200) begin
      if (t > 0) snoop_busy = 1'($urandom);
      if (pend) begin
        if (refilled) {tag_hit, line_valid, line_dirty, line_shared} = 4'b1101;
        else          {tag_hit, line_valid, line_dirty, line_shared} = {hit, valid, dirty, shared};
      end else begin
        {tag_hit, line_valid, line_dirty, line_shared} = 4'($urandom);
      end
      cur_req = write_req ? 1 : read_req ? 2 : invalid_req ? 3 : 0;
      if (cur_req != 0) begin
        if (cur_req != prev_req) begin
          obs_req.push_back(cur_req);
          req_cyc = 0;
        end
        req_cyc++;
        idx = (obs_req.size() > 3) ? 2 : obs_req.size() - 1;
        ace_ready = (req_cyc == waits[idx]);
      end else begin
        ace_ready = 1'($urandom);
      end
      prev_req = cur_req;

      @(negedge clk);
      checks++;
      if ($countones({write_req, read_req, invalid_req}) > 1) begin
        fails++;
        $display("FAIL %s req_onehot t=%0d got w/r/i=%b%b%b required at most one", name, t, write_req, read_req, invalid_req);
      end
      if (timeout_err) err_seen = 1;
      pend = lookup_en;
      if (lookup_en) n_lookup++;
      if (refill_we) begin n_refill++; refilled = 1; end
      if (data_we) n_data++;
      if (state_upd) upd_obs_seq = upd_obs_seq * 4 + int'(new_state) + 1;
      if (cpu_ready) begin
        obs_ready     = t;
        ready_data_ok = (data_we == we);
        done          = 1;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    obs_seq = 0;
    foreach (obs_req[i]) obs_seq = obs_seq * 4 + obs_req[i];

    checks++;
    if (obs_ready !== exp_ready) begin
      fails++;
      $display("FAIL %s ready_cycle got %0d required %0d", name, obs_ready, exp_ready);
    end
    checks++;
    if (obs_seq !== exp_seq) begin
      fails++;
      $display("FAIL %s ace_requests got code %0d required code %0d", name, obs_seq, exp_seq);
    end
    checks++;
    if (upd_obs_seq !== upd_exp_seq) begin
      fails++;
      $display("FAIL %s state_writes got code %0d required code %0d", name, upd_obs_seq, upd_exp_seq);
    end
    checks++;
    if (n_data !== int'(we)) begin
      fails++;
      $display("FAIL %s data_we_count got %0d required %0d", name, n_data, int'(we));
    end
    checks++;
    if (n_refill !== int'(alloc)) begin
      fails++;
      $display("FAIL %s refill_count got %0d required %0d", name, n_refill, int'(alloc));
    end
    checks++;
    if (n_lookup !== 1 + int'(alloc)) begin
      fails++;
      $display("FAIL %s lookup_count got %0d required %0d", name, n_lookup, 1 + int'(alloc));
    end
    checks++;
    if (done && !ready_data_ok) begin
      fails++;
      $display("FAIL %s data_we_with_ready got mismatch required data_we=%0b at cpu_ready", name, we);
    end
    checks++;
    if (err_seen) begin
      fails++;
      $display("FAIL %s timeout_err got 1 required 0", name);
    end

    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    ace_ready     = 1'b0;
    snoop_busy    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_req_valid = 1'b1; cpu_req_we = 1'b1; tag_hit = 1'b1;
    line_valid = 1'b1; line_dirty = 1'b1; line_shared = 1'b1;
    ace_ready = 1'b1; snoop_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs() !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs_during_rst got %b required %b", outs(), 11'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; cpu_req_valid = 1'b0; ace_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs_after_rst got %b required %b", outs(), 11'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_hit;
    run_txn("load_hit", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1);
    run_txn("store_hit_unique", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 1);
  endtask

  task automatic test_store_hit_shared;
    run_txn("store_hit_shared", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1, 1);
  endtask

  task automatic test_dirty_miss_store;
    run_txn("dirty_miss_store", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, 3, 4);
    run_txn("clean_miss_load", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1);
  endtask

  task automatic test_snoop_gate;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; snoop_busy = 1'b1; ace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (lookup_en !== 1'b0) begin
        fails++;
        $display("FAIL snoop_block cycle %0d lookup_en got %b required 0", i, lookup_en);
      end
      @(posedge clk); #1;
    end
    snoop_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (lookup_en !== 1'b1) begin
      fails++;
      $display("FAIL snoop_release lookup_en got %b required 1", lookup_en);
    end
    @(posedge clk); #1;
    snoop_busy = 1'b1;
    {tag_hit, line_valid, line_dirty, line_shared} = 4'b1100;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin
      fails++;
      $display("FAIL snoop_then_hit cpu_ready got %b required 1", cpu_ready);
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0; snoop_busy = 1'b0;
  endtask

  task automatic test_timeout;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; snoop_busy = 1'b0; ace_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (lookup_en !== 1'b1) begin
      fails++;
      $display("FAIL timeout_accept lookup_en got %b required 1", lookup_en);
    end
    @(posedge clk); #1;
    {tag_hit, line_valid, line_dirty, line_shared} = 4'b0000;
    @(negedge clk);
    for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
      @(posedge clk); #1;
      ace_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({read_req, timeout_err} !== 2'b10) begin
        fails++;
        $display("FAIL timeout_wait cycle %0d read_req/err got %b%b required 10", i, read_req, timeout_err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ace_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (outs() !== 11'd1) begin
        fails++;
        $display("FAIL timeout_error cycle %0d outputs got %b required %b", i, outs(), 11'd1);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; cpu_req_valid = 1'b0; ace_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 11'd0) begin
      fails++;
      $display("FAIL timeout_rst outputs got %b required %b", outs(), 11'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 11'd0) begin
      fails++;
      $display("FAIL timeout_cleared outputs got %b required %b", outs(), 11'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout_boundary;
    run_txn("alloc_ack_last_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TIMEOUT_CYCLES, 1, 1);
    run_txn("all_acks_last_cycle", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, TIMEOUT_CYCLES, TIMEOUT_CYCLES, TIMEOUT_CYCLES);
  endtask

  task automatic test_reset_mid_writeback;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; snoop_busy = 1'b0; ace_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    {tag_hit, line_valid, line_dirty, line_shared} = 4'b0110;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (write_req !== 1'b1) begin
      fails++;
      $display("FAIL mid_wb_entered write_req got %b required 1", write_req);
    end
    @(posedge clk); #1;
    rst = 1'b1; cpu_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 11'd0) begin
      fails++;
      $display("FAIL mid_wb_reset outputs got %b required %b", outs(), 11'd0);
    end
    @(posedge clk); #1;
    run_txn("after_abort_load_hit", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      run_txn("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(1, TIMEOUT_CYCLES)), int'($urandom_range(1, TIMEOUT_CYCLES)),
              int'($urandom_range(1, TIMEOUT_CYCLES)));
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    tag_hit = 1'b0; line_valid = 1'b0; line_dirty = 1'b0; line_shared = 1'b0;
    ace_ready = 1'b0; snoop_busy = 1'b0;
    test_reset();
    test_load_hit();
    test_store_hit_shared();
    test_dirty_miss_store();
    test_snoop_gate();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_writeback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
